// File: rtl/lsu_pkg.sv
// Shared types, address map constants and access-decode helpers for the MMIO load-store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  localparam logic [15:0] DMEM_BASE = 16'h0000;
  localparam logic [15:0] OUT_BASE  = 16'h1000;
  localparam logic [15:0] IN_BASE   = 16'h1001;

  localparam logic [15:0] OFF_LEDR   = 16'h0000;
  localparam logic [15:0] OFF_LEDG   = 16'h0010;
  localparam logic [15:0] OFF_HEX_LO = 16'h0020;
  localparam logic [15:0] OFF_HEX_HI = 16'h0024;
  localparam logic [15:0] OFF_LCD    = 16'h0030;
  localparam logic [15:0] OFF_SW     = 16'h0000;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_UNMAPPED = 2'b10
  } err_e;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic f3_legal(input logic wren, input logic [2:0] f3);
    if (wren) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data arrives LSB-aligned; replicate it so every lane carries the right bytes.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem_be.sv
// Word-wide data memory with per-byte write enables and a registered read port.
module lsu_dmem_be #(
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1 << AW) - 1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lsu_mmio_pipe.sv
// Load-store unit: valid/ready request, registered one-shot response, DMEM plus board MMIO,
// byte/half/word access with extension, error reporting and optional wait states.
module lsu_mmio_pipe
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_AW     = 9,
  parameter int unsigned N_HEX       = 8,
  parameter int unsigned SW_W        = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_wren,
  input  logic [2:0]         i_req_func3,
  input  logic [31:0]        i_req_addr,
  input  logic [31:0]        i_req_wdata,
  output logic               o_rsp_valid,
  output logic [31:0]        o_rsp_rdata,
  output logic [1:0]         o_rsp_err,
  input  logic [SW_W-1:0]    i_io_sw,
  output logic [31:0]        o_io_ledr,
  output logic [31:0]        o_io_ledg,
  output logic [7*N_HEX-1:0] o_io_hex,
  output logic [31:0]        o_io_lcd
);

  state_t             state_q;
  logic               ready_q, rsp_valid_q, wren_q, dmem_sel_q;
  err_e               err_q, req_err;
  logic [2:0]         f3_q;
  logic [31:0]        addr_q, io_q;
  logic [3:0]         cnt_q;
  logic [31:0]        ledr_q, ledg_q, lcd_q;
  logic [7*N_HEX-1:0] hex_q;
  logic [SW_W-1:0]    sw_meta_q, sw_sync_q;

  logic               accept, hit_dmem, hit_out, hit_in, do_store, to_resp;
  logic [15:0]        word_off, rd_off;
  logic [3:0]         be, dmem_be;
  logic [31:0]        st_data, rd_addr, io_word, sw_ext, mem_rdata, raw, lane, ext;
  logic [55:0]        hex_pad;
  logic [7:0][7:0]    hex_bytes;

  assign accept   = i_req_valid & ready_q;
  assign word_off = {i_req_addr[15:2], 2'b00};
  assign hit_dmem = i_req_addr[31:16] == DMEM_BASE;
  assign hit_out  = (i_req_addr[31:16] == OUT_BASE) &&
                    (word_off inside {OFF_LEDR, OFF_LEDG, OFF_HEX_LO, OFF_HEX_HI, OFF_LCD});
  assign hit_in   = (i_req_addr[31:16] == IN_BASE) && (word_off == OFF_SW);

  always_comb begin
    if (!f3_legal(i_req_wren, i_req_func3))              req_err = ERR_UNMAPPED;
    else if (misaligned(i_req_func3, i_req_addr[1:0]))   req_err = ERR_MISALIGN;
    else if (hit_dmem || hit_out || (hit_in && !i_req_wren)) req_err = ERR_OK;
    else                                                 req_err = ERR_UNMAPPED;
  end

  assign be       = byte_en(i_req_func3, i_req_addr[1:0]);
  assign st_data  = store_data(i_req_func3, i_req_wdata);
  assign do_store = accept & i_req_wren & (req_err == ERR_OK);
  assign dmem_be  = (do_store && hit_dmem) ? be : 4'b0000;

  // Loads sample on the edge that enters RESP; in IDLE that edge is the accept edge itself.
  assign to_resp = ((state_q == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                   ((state_q == WAIT) && (cnt_q == 4'd1));
  assign rd_addr = (state_q == IDLE) ? i_req_addr : addr_q;

  lsu_dmem_be #(
    .AW(DMEM_AW)
  ) u_dmem (
    .clk   (i_clk),
    .be    (dmem_be),
    .waddr (i_req_addr[DMEM_AW+1:2]),
    .wdata (st_data),
    .re    (to_resp),
    .raddr (rd_addr[DMEM_AW+1:2]),
    .rdata (mem_rdata)
  );

  always_comb begin
    sw_ext              = '0;
    sw_ext[SW_W-1:0]    = sw_sync_q;
    hex_pad             = '0;
    hex_pad[7*N_HEX-1:0] = hex_q;
    for (int k = 0; k < 8; k++) hex_bytes[k] = {1'b0, hex_pad[7*k +: 7]};
    rd_off  = {rd_addr[15:2], 2'b00};
    io_word = '0;
    if (rd_addr[31:16] == IN_BASE) begin
      io_word = sw_ext;
    end else begin
      case (rd_off)
        OFF_LEDR:   io_word = ledr_q;
        OFF_LEDG:   io_word = ledg_q;
        OFF_HEX_LO: io_word = hex_bytes[3:0];
        OFF_HEX_HI: io_word = hex_bytes[7:4];
        OFF_LCD:    io_word = lcd_q;
        default:    io_word = '0;
      endcase
    end
  end

  always_comb begin
    raw  = dmem_sel_q ? mem_rdata : io_q;
    lane = raw >> {addr_q[1:0], 3'b000};
    case (f3_q)
      F3_B:    ext = {{24{lane[7]}}, lane[7:0]};
      F3_H:    ext = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   ext = {24'b0, lane[7:0]};
      F3_HU:   ext = {16'b0, lane[15:0]};
      default: ext = raw;
    endcase
  end

  assign o_req_ready = ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = (rsp_valid_q && !wren_q && (err_q == ERR_OK)) ? ext : '0;
  assign o_rsp_err   = rsp_valid_q ? err_q : ERR_OK;
  assign o_io_ledr   = ledr_q;
  assign o_io_ledg   = ledg_q;
  assign o_io_hex    = hex_q;
  assign o_io_lcd    = lcd_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= i_io_sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= '0;
      hex_q  <= '0;
    end else if (do_store && hit_out) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          if (word_off == OFF_LEDR) ledr_q[8*b +: 8] <= st_data[8*b +: 8];
          if (word_off == OFF_LEDG) ledg_q[8*b +: 8] <= st_data[8*b +: 8];
          if (word_off == OFF_LCD)  lcd_q[8*b +: 8]  <= st_data[8*b +: 8];
        end
      end
      for (int k = 0; k < int'(N_HEX); k++) begin
        if (be[k % 4] && (word_off == ((k < 4) ? OFF_HEX_LO : OFF_HEX_HI)))
          hex_q[7*k +: 7] <= st_data[8*(k % 4) +: 7];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      err_q       <= ERR_OK;
      cnt_q       <= '0;
      addr_q      <= '0;
      f3_q        <= '0;
      wren_q      <= 1'b0;
      dmem_sel_q  <= 1'b0;
      io_q        <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (to_resp) io_q <= io_word;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q     <= i_req_addr;
            f3_q       <= i_req_func3;
            wren_q     <= i_req_wren;
            dmem_sel_q <= hit_dmem;
            err_q      <= req_err;
            ready_q    <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
